// File: rtl/cnt_pkg.sv
// Shared constants and helpers for the up/down modulo counter cells.
// Sizing figures describe the transistor-level cells; the logic helpers are used by the RTL.
package cnt_pkg;

  localparam real VTH_FRAC = 0.5;

  function automatic real rp_ohm(input int wp);
    return 80.0e3 / real'(wp);
  endfunction

  function automatic real rn_ohm(input int wn);
    return 40.0e3 / real'(wn);
  endfunction

  function automatic real cap_f(input int w);
    return 2.0e-15 * real'(w) * 0.0225;
  endfunction

  function automatic real vth_v(input real vdd);
    return VTH_FRAC * vdd;
  endfunction

  // Transmission-gate 2:1 mux: sel=1 passes b, sel=0 passes a.
  function automatic logic tg_mux(input logic sel, input logic a, input logic b);
    return sel ? b : a;
  endfunction

endpackage

// File: rtl/cnt_bit.sv
// One counter bit: flip-flop, load/toggle next-state mux and synchronous reset.
module cnt_bit
  import cnt_pkg::*;
(
  input  logic CK,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_load_bit,
  input  logic i_t,
  output logic o_q
);

  logic r_q;
  logic w_toggled;
  logic w_next;

  assign w_toggled = r_q ^ i_t;
  assign w_next    = tg_mux(i_load, w_toggled, i_load_bit);

  // NOTE: state registers use non-blocking assignments so every bit samples pre-edge values.
  always_ff @(posedge CK) begin
    if (i_rst) r_q <= 1'b0;
    else       r_q <= w_next;
  end

  assign o_q = r_q;

endmodule

// File: rtl/bin_counter_n.sv
// N-bit up/down counter with programmable modulus, parallel load and terminal count.
// Wrap-around and out-of-range loads are handled by forcing a load of the corrected value.
module bin_counter_n
  import cnt_pkg::*;
#(
  parameter int WP  = 4,
  parameter int WN  = 4,
  parameter int N   = 4,
  parameter int MOD = 2**N
) (
  input  logic         CK,
  input  logic         RST,
  input  logic         EN,
  input  logic         LD,
  input  logic         UP,
  input  logic [N-1:0] D,
  output logic [N-1:0] Q,
  output logic         TC,
  input  logic         VDD
);

  if (WP < 1 || WN < 1 || N < 1 || N > 16 || MOD < 2 || MOD > 2**N) begin : g_bad_param
    $error("bin_counter_n: illegal parameter set");
  end

  localparam logic [N:0]   MOD_W = MOD[N:0];
  localparam logic [N-1:0] MAX_Q = N'(MOD - 1);

  logic [N-1:0] w_q;
  logic [N:0]   w_t;
  logic [N:0]   w_d_mod;
  logic [N-1:0] w_load_val;
  logic         w_term;
  logic         w_wrap;
  logic         w_load_sel;

  assign w_term     = UP ? (w_q == MAX_Q) : (w_q == '0);
  assign w_wrap     = EN & w_term;
  assign w_load_sel = LD | w_wrap;
  assign w_d_mod    = {1'b0, D} % MOD_W;
  assign w_load_val = LD ? w_d_mod[N-1:0] : (UP ? '0 : MAX_Q);

  // Ripple chain: a bit toggles when all lower bits are 1 (up) or all 0 (down).
  assign w_t[0] = EN;
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign w_t[i+1] = w_t[i] & (UP ? w_q[i] : ~w_q[i]);

    cnt_bit u_bit (
      .CK         (CK),
      .i_rst      (RST),
      .i_load     (w_load_sel),
      .i_load_bit (w_load_val[i]),
      .i_t        (w_t[i]),
      .o_q        (w_q[i])
    );
  end

  // The chain's final carry is never consumed; wrap is decided by w_term against MOD.
  logic w_unused_carry;
  assign w_unused_carry = w_t[N];

  assign Q  = VDD ? w_q : '0;
  assign TC = VDD & EN & ~RST & ~LD & w_term;

endmodule

// File: tb/tb_bin_counter_n.sv
// Directed self-checking bench for bin_counter_n at N=4, MOD=10.
module tb_bin_counter_n;

  logic       CK = 1'b0;
  logic       RST = 1'b0;
  logic       EN = 1'b0;
  logic       LD = 1'b0;
  logic       UP = 1'b1;
  logic [3:0] D = '0;
  logic [3:0] Q;
  logic       TC;
  logic       VDD = 1'b1;

  int checks   = 0;
  int failures = 0;

  bin_counter_n #(.WP(4), .WN(4), .N(4), .MOD(10)) dut (
    .CK  (CK),
    .RST (RST),
    .EN  (EN),
    .LD  (LD),
    .UP  (UP),
    .D   (D),
    .Q   (Q),
    .TC  (TC),
    .VDD (VDD)
  );

  always #5 CK = ~CK;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  initial begin
    // Reset, then count up through the wrap at 9.
    #2;
    RST = 1'b1; EN = 1'b1; LD = 1'b1; D = 4'd7;
    tick();
    check("rst_q", 16'(Q), 16'd0);
    check("rst_tc", 16'(TC), 16'd0);
    RST = 1'b0; LD = 1'b0; EN = 1'b1; UP = 1'b1;
    #1;
    check("up_tc_start", 16'(TC), 16'd0);
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("up_q_%0d", i), 16'(Q), 16'(i % 10));
      check($sformatf("up_tc_%0d", i), 16'(TC), 16'((i % 10) == 9));
    end

    // Down wrap from 0 to 9.
    RST = 1'b1;
    tick();
    RST = 1'b0; UP = 1'b0; EN = 1'b1;
    #1;
    check("dn_tc_at0", 16'(TC), 16'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("dn_q_%0d", i), 16'(Q), 16'(9 - i));
      check($sformatf("dn_tc_%0d", i), 16'(TC), 16'd0);
    end

    // Loads, including out-of-range values.
    EN = 1'b0; LD = 1'b1; D = 4'd13;
    tick();
    check("ld13_q", 16'(Q), 16'd3);
    EN = 1'b1; D = 4'd6;
    tick();
    check("ld6_en_q", 16'(Q), 16'd6);
    D = 4'd15;
    tick();
    check("ld15_q", 16'(Q), 16'd5);
    D = 4'd10;
    tick();
    check("ld10_q", 16'(Q), 16'd0);

    // Priority: reset beats load and enable.
    RST = 1'b1; LD = 1'b1; EN = 1'b1; D = 4'd5;
    tick();
    check("prio_q", 16'(Q), 16'd0);
    RST = 1'b0; LD = 1'b0; UP = 1'b1;
    tick();
    tick();
    check("prio_cnt_q", 16'(Q), 16'd2);
    EN = 1'b0;
    #2 RST = 1'b1;
    #2 RST = 1'b0;
    tick();
    check("mid_rst_q", 16'(Q), 16'd2);

    // Hold with EN=0.
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold_q_%0d", i), 16'(Q), 16'd2);
    end

    // Direction change between edges takes effect at the next edge.
    LD = 1'b1; D = 4'd4;
    tick();
    check("ld4_q", 16'(Q), 16'd4);
    LD = 1'b0; EN = 1'b1; UP = 1'b1;
    @(negedge CK);
    UP = 1'b0;
    tick();
    check("updn_q", 16'(Q), 16'd3);

    // TC gating by LD and RST at Q=9.
    EN = 1'b0; LD = 1'b1; D = 4'd9;
    tick();
    LD = 1'b0; EN = 1'b1; UP = 1'b1;
    #1;
    check("tc_q9", 16'(TC), 16'd1);
    LD = 1'b1;
    #1;
    check("tc_ld_gate", 16'(TC), 16'd0);
    LD = 1'b0; RST = 1'b1;
    #1;
    check("tc_rst_gate", 16'(TC), 16'd0);
    RST = 1'b0; EN = 1'b0;
    #1;
    check("tc_en_gate", 16'(TC), 16'd0);
    UP = 1'b0;
    #1;
    check("tc_dn_q9", 16'(TC), 16'd0);

    // Outputs follow the supply level.
    VDD = 1'b0;
    #1;
    check("vdd0_q", 16'(Q), 16'd0);
    VDD = 1'b1;
    #1;
    check("vdd1_q", 16'(Q), 16'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bin_counter_n.md
BIN_COUNTER_N -- requirements
Module: bin_counter_n

Interface
REQ-001 Parameter WP, default 4: PMOS width in lambdas, for every transistor-level sub-cell.
REQ-002 Parameter WN, default 4: NMOS width in lambdas, for every transistor-level sub-cell.
REQ-003 Parameter N, default 4: counter width in bits, legal range 1..16.
REQ-004 Parameter MOD, default 2**N: count modulus, legal range 2..2**N.
REQ-005 Port CK, input, xreal x1: the only clock; the block acts on its rising edge.
REQ-006 Port RST, input, xreal x1: reset, synchronous and active-high.
REQ-007 Port EN, input, xreal x1: count enable.
REQ-008 Port LD, input, xreal x1: parallel load strobe.
REQ-009 Port UP, input, xreal x1: direction; 1 = up, 0 = down.
REQ-010 Port D, input, xreal xN: parallel load value, LSB at D[0].
REQ-011 Port Q, output, xreal xN: count value, LSB at Q[0].
REQ-012 Port TC, output, xreal x1: terminal count.
REQ-013 Port VDD, input, xreal x1: supply; sets the logic-high level.

Function
REQ-014 An input reads as logic 1 when its voltage is above VDD/2, else logic 0.
REQ-015 Outputs drive to VDD or ground through RC stages sized by WP and WN.
REQ-016 Every state change occurs only at a rising CK edge.
REQ-017 Q settles within one clock-to-Q delay of the RC model after the edge; no other latency exists.
REQ-018 Edge priority is RST > LD > EN; with none of them asserted, Q holds.
REQ-019 RST=1: Q becomes 0.
REQ-020 LD=1: Q becomes D; if D >= MOD, Q becomes D mod MOD.
REQ-021 LD takes effect regardless of EN.
REQ-022 EN=1 and UP=1: Q becomes Q+1; at Q=MOD-1, Q wraps to 0.
REQ-023 EN=1 and UP=0: Q becomes Q-1; at Q=0, Q wraps to MOD-1.
REQ-024 A change of UP between edges has no effect until the next edge.
REQ-025 TC is combinational: 1 when EN=1 and ((UP=1 and Q=MOD-1) or (UP=0 and Q=0)), else 0.
REQ-026 TC is forced to 0 while RST=1 or LD=1.
REQ-027 Q never holds a value >= MOD after any edge.

Reset
REQ-028 RST is sampled only at the rising CK edge; asserting it between edges does not change Q.
REQ-029 After a reset edge, Q=0 and TC=0.
REQ-030 Reset overrides any simultaneous LD or EN.
REQ-031 Reset in the middle of a count sequence discards the count; counting resumes from 0 at the first edge with RST=0.
REQ-032 Q is not required to have a defined value before the first reset edge.

Structure
REQ-033 A shared package cnt_pkg holds the sizing-derived constants used by every sub-cell:
  - Rp = 80e3/WP and Rn = 40e3/WN
  - gate and junction caps = 2e-15*W*0.0225
REQ-034 cnt_pkg also holds the logic threshold fraction 0.5.
REQ-035 One sub-module, cnt_bit, contains one FF, a next-state mux made from TG_mux cells, and the up/down toggle logic for one bit.
REQ-036 bin_counter_n instantiates N copies of cnt_bit with a ripple carry/borrow chain.
REQ-037 Modulus detection, load select and reset gating sit in bin_counter_n.

Verification (VDD=1.0, N=4, MOD=10)
REQ-038 Reset: RST=1 for 1 edge, then EN=1, UP=1 for 12 edges -> Q=1..9,0,1,2; TC=1 exactly while Q=9.
REQ-039 Down wrap: after reset, EN=1, UP=0 for 3 edges -> Q=9,8,7; TC=1 only before the first edge (Q=0).
REQ-040 Load: LD=1, D=13 with EN=0 -> Q=3; then LD=1, D=6 with EN=1 -> Q=6.
REQ-041 Priority: RST=1, LD=1, EN=1, D=5 on the same edge -> Q=0; RST pulse held only between edges -> Q unchanged.
REQ-042 Hold and direction change: EN=0 for 5 edges -> Q constant; then Q=4, UP switched 1->0 mid-cycle -> the next edge gives Q=3.
REQ-043 Thresholds: inputs driven at 0.45 V and then 0.55 V -> read as 0 and 1 respectively; outputs settle to within 2% of VDD or 0 before the next edge at a 100 MHz CK.
